// File: rtl/logs_voice_alloc.sv
`default_nettype none
// =============================================================================
// Module   : logs_voice_alloc
// Brief    : Note-on/off voice allocator; one-voice-per-cycle scan, then commit.
//            Voice stealing is built only when LOGS_VALLOC_STEAL_EN is defined.
// Revision : 1.0
// =============================================================================
module logs_voice_alloc #(
  parameter int NVOICES = 4,
  parameter int PW      = 8,
  parameter int AGEW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_on,
  input  logic [PW-1:0]         cmd_period,
  output logic [NVOICES-1:0]    voice_active,
  output logic [NVOICES*PW-1:0] voice_period,
  output logic                  evict,
  output logic                  busy
);

  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NVOICES - 1);
  localparam logic [AGEW-1:0] AGE_MAX  = {AGEW{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                on_q, on_d;
  logic [PW-1:0]       per_q, per_d;
  logic                m_found_q, m_found_d;
  logic [IW-1:0]       m_idx_q, m_idx_d;
  logic                f_found_q, f_found_d;
  logic [IW-1:0]       f_idx_q, f_idx_d;
  logic [NVOICES-1:0]  active_q, active_d;
  logic [PW-1:0]       period_q [NVOICES];
  logic [PW-1:0]       period_d [NVOICES];
  logic [AGEW-1:0]     age_q [NVOICES];
  logic [AGEW-1:0]     age_d [NVOICES];
`ifdef LOGS_VALLOC_STEAL_EN
  logic                o_found_q, o_found_d;
  logic [IW-1:0]       o_idx_q, o_idx_d;
  logic [AGEW-1:0]     o_age_q, o_age_d;
  logic                evict_q, evict_d;
`endif

  logic                w_take;
  logic                w_load;
  logic [IW-1:0]       w_tgt;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    on_d      = on_q;
    per_d     = per_q;
    m_found_d = m_found_q;
    m_idx_d   = m_idx_q;
    f_found_d = f_found_q;
    f_idx_d   = f_idx_q;
    active_d  = active_q;
    period_d  = period_q;
    age_d     = age_q;
    w_take    = 1'b0;
    w_load    = 1'b0;
    w_tgt     = '0;
`ifdef LOGS_VALLOC_STEAL_EN
    o_found_d = o_found_q;
    o_idx_d   = o_idx_q;
    o_age_d   = o_age_q;
    evict_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          on_d      = cmd_on;
          per_d     = cmd_period;
          idx_d     = '0;
          m_found_d = 1'b0;
          m_idx_d   = '0;
          f_found_d = 1'b0;
          f_idx_d   = '0;
`ifdef LOGS_VALLOC_STEAL_EN
          o_found_d = 1'b0;
          o_idx_d   = '0;
          o_age_d   = '0;
`endif
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // First hit wins for match/free; strict '>' keeps the lowest index on age ties.
        if (active_q[idx_q] && period_q[idx_q] == per_q && !m_found_q) begin
          m_found_d = 1'b1;
          m_idx_d   = idx_q;
        end
        if (!active_q[idx_q] && !f_found_q) begin
          f_found_d = 1'b1;
          f_idx_d   = idx_q;
        end
`ifdef LOGS_VALLOC_STEAL_EN
        if (active_q[idx_q] && (!o_found_q || age_q[idx_q] > o_age_q)) begin
          o_found_d = 1'b1;
          o_idx_d   = idx_q;
          o_age_d   = age_q[idx_q];
        end
`endif
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (on_q && per_q != '0) begin
          if (m_found_q) begin
            w_take = 1'b1;
            w_tgt  = m_idx_q;
          end else if (f_found_q) begin
            w_take = 1'b1;
            w_load = 1'b1;
            w_tgt  = f_idx_q;
          end
`ifdef LOGS_VALLOC_STEAL_EN
          else begin
            w_take  = 1'b1;
            w_load  = 1'b1;
            w_tgt   = o_idx_q;
            evict_d = 1'b1;
          end
`endif
          if (w_take) begin
            for (int i = 0; i < NVOICES; i++) begin
              if (IW'(i) == w_tgt) begin
                active_d[i] = 1'b1;
                age_d[i]    = '0;
                if (w_load) period_d[i] = per_q;
              end else if (active_q[i] && age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + AGEW'(1);
              end
            end
          end
        end else if (!on_q) begin
          // Period 0 on a note-off means all-notes-off.
          if (per_q == '0)    active_d = '0;
          else if (m_found_q) active_d[m_idx_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      on_q      <= 1'b0;
      per_q     <= '0;
      m_found_q <= 1'b0;
      m_idx_q   <= '0;
      f_found_q <= 1'b0;
      f_idx_q   <= '0;
      active_q  <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        period_q[i] <= '0;
        age_q[i]    <= '0;
      end
`ifdef LOGS_VALLOC_STEAL_EN
      o_found_q <= 1'b0;
      o_idx_q   <= '0;
      o_age_q   <= '0;
      evict_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      on_q      <= on_d;
      per_q     <= per_d;
      m_found_q <= m_found_d;
      m_idx_q   <= m_idx_d;
      f_found_q <= f_found_d;
      f_idx_q   <= f_idx_d;
      active_q  <= active_d;
      period_q  <= period_d;
      age_q     <= age_d;
`ifdef LOGS_VALLOC_STEAL_EN
      o_found_q <= o_found_d;
      o_idx_q   <= o_idx_d;
      o_age_q   <= o_age_d;
      evict_q   <= evict_d;
`endif
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign voice_active = active_q;
`ifdef LOGS_VALLOC_STEAL_EN
  assign evict = evict_q;
`else
  assign evict = 1'b0;
`endif

  generate
    for (genvar g = 0; g < NVOICES; g++) begin : g_vper
      assign voice_period[g*PW +: PW] = period_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_logs_voice_alloc.sv
`default_nettype none
// =============================================================================
// Module   : tb_logs_voice_alloc
// Brief    : Directed self-checking bench for logs_voice_alloc (NVOICES=4, AGEW=2).
// Revision : 1.0
// =============================================================================
module tb_logs_voice_alloc;
  localparam int NV   = 4;
  localparam int PW   = 8;
  localparam int AGEW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_on;
  logic [PW-1:0]   cmd_period;
  logic [NV-1:0]   voice_active;
  logic [NV*PW-1:0] voice_period;
  logic            evict;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  int lows, evs;

  logs_voice_alloc #(.NVOICES(NV), .PW(PW), .AGEW(AGEW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_on(cmd_on), .cmd_period(cmd_period), .voice_active(voice_active),
    .voice_period(voice_period), .evict(evict), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ages packed voice0 in the MSBs.
  function automatic logic [7:0] ages();
    return {dut.age_q[0], dut.age_q[1], dut.age_q[2], dut.age_q[3]};
  endfunction

  // Issue one command, count cycles with cmd_ready low and cycles with evict high.
  task automatic send(input logic on, input logic [PW-1:0] per,
                      output int n_low, output int n_ev);
    int c;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_on = on; cmd_period = per;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_low = 0; n_ev = 0; c = 0;
    while (!cmd_ready && c < 20) begin
      n_low++; n_ev += int'(evict); c++;
      @(posedge clk); #1;
    end
    if (c >= 20) check("timeout", 32'(cmd_ready), 32'd1);
    n_ev += int'(evict);
    @(posedge clk); #1;
    n_ev += int'(evict);
  endtask

  initial begin
    int c;
    reset = 1'b1; cmd_valid = 1'b0; cmd_on = 1'b0; cmd_period = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", 32'(voice_active), 32'h0);
    check("rst_period", voice_period, 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_evict", 32'(evict), 32'd0);
    @(negedge clk); reset = 1'b0;

    send(1'b1, 8'h40, lows, evs);
    check("lat_ready_low", 32'(lows), 32'd5);
    check("first_active", 32'(voice_active), 32'h1);
    check("first_period", voice_period, 32'h00000040);

    send(1'b0, 8'h00, lows, evs);
    check("alloff_1", 32'(voice_active), 32'h0);

    send(1'b1, 8'h10, lows, evs);
    send(1'b1, 8'h20, lows, evs);
    send(1'b1, 8'h30, lows, evs);
    send(1'b1, 8'h40, lows, evs);
    check("fill_active", 32'(voice_active), 32'hf);
    check("fill_period", voice_period, 32'h40302010);
    check("fill_ages", 32'(ages()), 32'he4);

    send(1'b1, 8'h77, lows, evs);
    check("full_active", 32'(voice_active), 32'hf);
`ifdef LOGS_VALLOC_STEAL_EN
    check("steal_period", voice_period, 32'h40302077);
    check("steal_evict", 32'(evs), 32'd1);
    check("steal_ages", 32'(ages()), 32'h39);
`else
    check("drop_period", voice_period, 32'h40302010);
    check("drop_evict", 32'(evs), 32'd0);
    check("drop_ages", 32'(ages()), 32'he4);
`endif

    send(1'b1, 8'h30, lows, evs);
    check("retrig_active", 32'(voice_active), 32'hf);
    check("retrig_evict", 32'(evs), 32'd0);
    check("retrig_age2", 32'(dut.age_q[2]), 32'd0);
`ifdef LOGS_VALLOC_STEAL_EN
    check("retrig_ages", 32'(ages()), 32'h72);
`else
    check("retrig_ages", 32'(ages()), 32'hf1);
`endif

    send(1'b0, 8'h20, lows, evs);
    check("off20_active", 32'(voice_active), 32'hd);
    send(1'b1, 8'h50, lows, evs);
    check("on50_active", 32'(voice_active), 32'hf);
    check("on50_v1", 32'(voice_period[15:8]), 32'h50);
`ifdef LOGS_VALLOC_STEAL_EN
    check("on50_ages", 32'(ages()), 32'h87);
`else
    check("on50_ages", 32'(ages()), 32'hc6);
`endif

    send(1'b0, 8'h99, lows, evs);
    check("off99_active", 32'(voice_active), 32'hf);
    send(1'b1, 8'h00, lows, evs);
    check("on0_active", 32'(voice_active), 32'hf);
`ifdef LOGS_VALLOC_STEAL_EN
    check("on0_period", voice_period, 32'h40305077);
    check("on0_ages", 32'(ages()), 32'h87);
`else
    check("on0_period", voice_period, 32'h40305010);
    check("on0_ages", 32'(ages()), 32'hc6);
`endif

    for (int k = 0; k < 5; k++) begin
      send(1'b1, 8'h50, lows, evs);
      if (k >= 1) check("sat_age0", 32'(dut.age_q[0]), 32'd3);
    end
    check("sat_ages", 32'(ages()), 32'hcf);

    send(1'b0, 8'h00, lows, evs);
    check("alloff_2", 32'(voice_active), 32'h0);

    // Reset in the middle of a scan; the held command is then taken afresh.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_on = 1'b1; cmd_period = 8'h60;
    @(posedge clk); #1;
    check("busy_scan", 32'(busy), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_active", 32'(voice_active), 32'h0);
    check("midrst_period", voice_period, 32'h0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_evict", 32'(evict), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("reaccept_busy", 32'(busy), 32'd1);
    c = 0;
    while (!cmd_ready && c < 20) begin
      c++;
      @(posedge clk); #1;
    end
    check("reaccept_done", 32'(cmd_ready), 32'd1);
    check("reaccept_active", 32'(voice_active), 32'h1);
    check("reaccept_period", voice_period, 32'h00000060);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
